mem_access_unit: RTL

- MEM-stage engine between the EX/MEM register and the MEM/WB register in the 5-stage pipeline.
- Performs loads and stores against a data memory with a req/ack handshake and variable latency.
- Steers byte and halfword lanes, and sign- or zero-extends load data.
- Stalls the upstream pipeline while an access is in flight and presents WB-ready values for MEM/WB to capture.

---
 rtl/mips_pkg.sv | 34 +++
 rtl/mem_lane_align.sv | 69 ++++++
 rtl/mem_access_unit.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the MEM stage:
//   - mem_size_e   : MemSize encodings (byte / half / word / reserved)
//   - mau_state_e  : state encoding of the memory access unit FSM
//   - is_misaligned: alignment check for a given access size and address offset
// -----------------------------------------------------------------------------
package mips_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11   // behaves as a word access
  } mem_size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_DONE = 2'b10
  } mau_state_e;

  // A halfword needs addr[0]==0; a word (and the reserved size) needs addr[1:0]==0.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic bad_s;
    case (size)
      SZ_BYTE: bad_s = 1'b0;
      SZ_HALF: bad_s = off[0];
      default: bad_s = (off != 2'b00);
    endcase
    return bad_s;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// -----------------------------------------------------------------------------
// mem_lane_align
// Combinational little-endian lane steering for the MEM stage.
// The byte-lane layout is that of a 32-bit data bus.
// Store side:
//   st_size, st_off, st_data -> be (byte enables), wdata (lane-replicated data)
// Load side:
//   ld_size, ld_off, ld_unsigned, ld_rdata -> ld_data (extracted, sign/zero-extended)
// -----------------------------------------------------------------------------
module mem_lane_align
  import mips_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [1:0]   st_size,
  input  logic [1:0]   st_off,
  input  logic [N-1:0] st_data,
  output logic [3:0]   be,
  output logic [N-1:0] wdata,
  input  logic [1:0]   ld_size,
  input  logic [1:0]   ld_off,
  input  logic         ld_unsigned,
  input  logic [N-1:0] ld_rdata,
  output logic [N-1:0] ld_data
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Byte enables and store-data replication; the memory picks lanes via be.
  always_comb begin
    be    = 4'b0000;
    wdata = st_data;
    case (st_size)
      SZ_BYTE: begin
        be    = 4'b0001 << st_off;
        wdata = N'({4{st_data[7:0]}});
      end
      SZ_HALF: begin
        be    = st_off[1] ? 4'b1100 : 4'b0011;
        wdata = N'({2{st_data[15:0]}});
      end
      default: begin
        be    = 4'b1111;
        wdata = st_data;
      end
    endcase
  end

  // Load lane extraction followed by sign or zero extension.
  always_comb begin
    byte_s  = ld_rdata[7:0];
    half_s  = ld_rdata[15:0];
    ld_data = ld_rdata;
    case (ld_off)
      2'b00:   byte_s = ld_rdata[7:0];
      2'b01:   byte_s = ld_rdata[15:8];
      2'b10:   byte_s = ld_rdata[23:16];
      default: byte_s = ld_rdata[31:24];
    endcase
    half_s = ld_off[1] ? ld_rdata[31:16] : ld_rdata[15:0];
    case (ld_size)
      SZ_BYTE: ld_data = {{(N-8){~ld_unsigned & byte_s[7]}}, byte_s};
      SZ_HALF: ld_data = {{(N-16){~ld_unsigned & half_s[15]}}, half_s};
      default: ld_data = ld_rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
// MEM-stage engine between EX/MEM and MEM/WB. Issues loads/stores to a data
// memory over a req/ack handshake with variable latency, stalls upstream while
// the access is in flight and presents WB-ready values for MEM/WB.
// State updates happen on the falling clock edge like the pipeline registers.
// Ports:
//   clk, reset (async, active-low)
//   EX/MEM side : ALU_result, Write_data, WriteRegister, PC_4, MemRead,
//                 MemWrite, MemSize, MemUnsigned, MemtoReg, RegWrite
//   memory side : mem_req, mem_we, mem_addr, mem_wdata, mem_be (registered),
//                 mem_rdata, mem_ack
//   pipeline    : stall, addr_error, bus_error
//   MEM/WB side : ALU_result_out, Read_data_out, WriteRegister_out, PC_4_out,
//                 MemtoReg_out, RegWrite_out
// -----------------------------------------------------------------------------
module mem_access_unit
  import mips_pkg::*;
#(
  parameter int N       = 32,
  parameter int TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] ALU_result,
  input  logic [N-1:0] Write_data,
  input  logic [4:0]   WriteRegister,
  input  logic [N-1:0] PC_4,
  input  logic         MemRead,
  input  logic         MemWrite,
  input  logic [1:0]   MemSize,
  input  logic         MemUnsigned,
  input  logic         MemtoReg,
  input  logic         RegWrite,
  output logic         mem_req,
  output logic         mem_we,
  output logic [N-1:0] mem_addr,
  output logic [N-1:0] mem_wdata,
  output logic [3:0]   mem_be,
  input  logic [N-1:0] mem_rdata,
  input  logic         mem_ack,
  output logic         stall,
  output logic         addr_error,
  output logic         bus_error,
  output logic [N-1:0] ALU_result_out,
  output logic [N-1:0] Read_data_out,
  output logic [4:0]   WriteRegister_out,
  output logic [N-1:0] PC_4_out,
  output logic         MemtoReg_out,
  output logic         RegWrite_out
);

  localparam int            CW       = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  mau_state_e   state_r, state_nx_s;
  logic [CW-1:0] cnt_r;
  logic         mem_req_r, mem_we_r;
  logic [N-1:0] mem_addr_r, mem_wdata_r;
  logic [3:0]   mem_be_r;
  logic [1:0]   size_r, off_r;
  logic         uns_r;
  logic [N-1:0] rdata_r;
  logic         err_r;

  logic         access_s, misaligned_s, start_s, ack_s, timeout_s;
  logic         stall_s, addr_err_s, bus_err_s, kill_s;
  logic [3:0]   be_s;
  logic [N-1:0] wdata_s, ld_data_s;

  assign access_s     = MemRead | MemWrite;
  assign misaligned_s = access_s & is_misaligned(MemSize, ALU_result[1:0]);
  assign start_s      = (state_r == ST_IDLE) & access_s & ~misaligned_s;
  assign ack_s        = (state_r == ST_WAIT) & mem_ack;
  // An ack on the last wait cycle still completes the access normally.
  assign timeout_s    = (state_r == ST_WAIT) & ~mem_ack & (cnt_r == CNT_LAST);

  // Store lanes come from the live EX/MEM inputs; load lanes from the latched access.
  mem_lane_align #(.N(N)) u_align (
    .st_size     (MemSize),
    .st_off      (ALU_result[1:0]),
    .st_data     (Write_data),
    .be          (be_s),
    .wdata       (wdata_s),
    .ld_size     (size_r),
    .ld_off      (off_r),
    .ld_unsigned (uns_r),
    .ld_rdata    (mem_rdata),
    .ld_data     (ld_data_s)
  );

  // FSM state register.
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state decode and per-state control strobes.
  always_comb begin
    state_nx_s = state_r;
    stall_s    = 1'b0;
    addr_err_s = 1'b0;
    bus_err_s  = 1'b0;
    kill_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (access_s) begin
          if (misaligned_s) begin
            addr_err_s = 1'b1;
            kill_s     = 1'b1;
            state_nx_s = ST_IDLE;
          end else begin
            stall_s    = 1'b1;
            state_nx_s = ST_WAIT;
          end
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        stall_s = 1'b1;
        if (mem_ack) begin
          state_nx_s = ST_DONE;
        end else if (cnt_r == CNT_LAST) begin
          bus_err_s  = 1'b1;
          state_nx_s = ST_DONE;
        end else begin
          state_nx_s = ST_WAIT;
        end
      end
      ST_DONE: begin
        // A timed-out instruction must not write back.
        kill_s     = err_r;
        state_nx_s = ST_IDLE;
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // Memory request, wait counter and load-capture registers.
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r       <= '0;
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
      mem_be_r    <= 4'b0000;
      size_r      <= 2'b00;
      off_r       <= 2'b00;
      uns_r       <= 1'b0;
      rdata_r     <= '0;
      err_r       <= 1'b0;
    end else if (start_s) begin
      cnt_r       <= '0;
      mem_req_r   <= 1'b1;
      mem_we_r    <= MemWrite;
      mem_addr_r  <= {ALU_result[N-1:2], 2'b00};
      mem_wdata_r <= wdata_s;
      mem_be_r    <= be_s;
      size_r      <= MemSize;
      off_r       <= ALU_result[1:0];
      uns_r       <= MemUnsigned;
      rdata_r     <= '0;
      err_r       <= 1'b0;
    end else if (ack_s) begin
      mem_req_r <= 1'b0;
      rdata_r   <= mem_we_r ? '0 : ld_data_s;
    end else if (timeout_s) begin
      mem_req_r <= 1'b0;
      rdata_r   <= '0;
      err_r     <= 1'b1;
    end else if (state_r == ST_WAIT) begin
      cnt_r <= cnt_r + CW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign mem_req   = mem_req_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign mem_be    = mem_be_r;

  // Pipeline-facing outputs; forced to zero while reset is held low.
  always_comb begin
    stall             = 1'b0;
    addr_error        = 1'b0;
    bus_error         = 1'b0;
    ALU_result_out    = '0;
    Read_data_out     = '0;
    WriteRegister_out = 5'd0;
    PC_4_out          = '0;
    MemtoReg_out      = 1'b0;
    RegWrite_out      = 1'b0;
    if (reset) begin
      stall             = stall_s;
      addr_error        = addr_err_s;
      bus_error         = bus_err_s;
      ALU_result_out    = ALU_result;
      Read_data_out     = (state_r == ST_DONE) ? rdata_r : '0;
      WriteRegister_out = WriteRegister;
      PC_4_out          = PC_4;
      // Stalled cycles present a bubble to MEM/WB.
      MemtoReg_out      = MemtoReg & ~stall_s;
      RegWrite_out      = RegWrite & ~stall_s & ~kill_s;
    end else begin
      stall = 1'b0;
    end
  end

endmodule
